pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, meaning the exception entry PC.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port resetn, input, 1, meaning reset: asynchronous, active-low.
REQ-004 SHALL have port stall_req_if, input, 1, meaning the instruction bus is waiting.
REQ-005 SHALL have port stall_req_id, input, 1, meaning a load-use or mfc0-use hazard in decode.
REQ-006 SHALL have port stall_req_ex, input, 1, meaning a multi-cycle execute operation (div/mult) is busy.
REQ-007 SHALL have port stall_req_mem, input, 1, meaning the data bus is waiting.
REQ-008 SHALL have port exc_req, input, 1, meaning the MEM-stage instruction raises an exception.
REQ-009 SHALL have port eret_req, input, 1, meaning the MEM-stage instruction is ERET.
REQ-010 SHALL have port cp0_epc, input, 32, meaning the current EPC value.
REQ-011 SHALL have port id_next_isdelayslot, input, 1, meaning the decode instruction is a branch or jump.
REQ-012 SHALL have port stall, output, 6, meaning {wb,mem,ex,id,if,pc} hold enables.
REQ-013 SHALL have port flush, output, 1, meaning all pipeline registers clear.
REQ-014 SHALL have port new_pc_valid, output, 1, meaning the PC loads new_pc this cycle.
REQ-015 SHALL have port new_pc, output, 32, meaning the redirect target.
REQ-016 SHALL have port id_isdelayslot, output, 1, meaning the instruction now in ID is a delay slot.
REQ-017 SHALL have port stall_cycles, output, 32, meaning the performance counter of stalled cycles.

Function
REQ-018 SHALL implement FSM states RUN, WAIT_BUS, FLUSH.
REQ-019 SHALL, in RUN with no exc_req/eret_req, encode stall by priority: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-020 SHALL, in RUN on exc_req|eret_req, latch target: EXC_VECTOR if exc_req (exc_req wins when both are set), else cp0_epc.
REQ-021 SHALL, on that RUN request, force stall=6'b111111 for the same cycle.
REQ-022 SHALL, on that RUN request, go to FLUSH if stall_req_if=0 and stall_req_mem=0, else go to WAIT_BUS.
REQ-023 SHALL, in WAIT_BUS, hold stall=6'b111111 and ignore exc_req/eret_req.
REQ-024 SHALL, in WAIT_BUS, move to FLUSH in the first cycle both bus requests are sampled low.
REQ-025 SHALL, in FLUSH, assert flush=1, new_pc_valid=1 and new_pc=latched target, with stall=0, for exactly one cycle, then return to RUN.
REQ-026 SHALL ignore exc_req/eret_req while in FLUSH.
REQ-027 SHALL give new_pc_valid a latency of 1 cycle after the request in the no-wait case, and 1 cycle after bus-idle in the WAIT_BUS case.
REQ-028 SHALL drive new_pc=0 whenever new_pc_valid=0.
REQ-029 SHALL update id_isdelayslot <= id_next_isdelayslot when stall[2]=0 and flush=0.
REQ-030 SHALL hold id_isdelayslot when stall[2]=1.
REQ-031 SHALL clear id_isdelayslot to 0 on flush.
REQ-032 SHALL increment stall_cycles when stall[1]=1, saturating at 32'hFFFFFFFF with no wrap.
REQ-033 SHALL handle an exception arriving in the same cycle as stall_req_id/ex by letting the exception win, per REQ-021.

Reset
REQ-034 SHALL, on resetn=0, set state=RUN, latched target=0, id_isdelayslot=0, stall_cycles=0, stall=0, flush=0, new_pc_valid=0, new_pc=0.
REQ-035 SHALL abandon any pending redirect on reset asserted in WAIT_BUS or FLUSH, with no flush issued after reset release.

Structure
REQ-036 SHALL place the state enum, the stall encodings and the EXC_VECTOR default in the shared CPU package.
REQ-037 SHALL be a single module with no sub-modules; the stall priority encoder is a local function.

Verification
REQ-038 SHALL cover stall priority: stall_req_id=1 and stall_req_ex=1 together -> stall=6'b001111; stall_req_mem added -> 6'b011111.
REQ-039 SHALL cover an immediate exception: exc_req=1 with buses idle -> stall=6'b111111 that cycle; next cycle flush=1, new_pc=32'hBFC00380; following cycle flush=0.
REQ-040 SHALL cover ERET during a bus wait: eret_req=1, cp0_epc=32'h80001234, stall_req_mem=1 for 3 cycles -> 3 WAIT_BUS cycles with stall=6'b111111, then flush and new_pc=32'h80001234.
REQ-041 SHALL cover the delay-slot flag: id_next_isdelayslot=1 with stall[2]=1 for 2 cycles -> id_isdelayslot unchanged, updates on the first unstalled cycle, and clears on flush.
REQ-042 SHALL cover reset mid-operation: resetn pulsed low in WAIT_BUS -> all outputs 0 immediately, with no flush after release.
REQ-043 SHALL cover counter saturation: stall_cycles preset near 32'hFFFFFFFE with 3 stalled cycles -> stays 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU package: pipeline controller state encoding,
// stall hold-enable patterns and the default exception entry PC.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    WAIT_BUS,
    FLUSH
  } state_t;

  // {wb,mem,ex,id,if,pc} hold enables
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall priority, exception/ERET redirect
// FSM (RUN/WAIT_BUS/FLUSH), delay-slot flag, stall cycle counter.
// Ports: clk, resetn (async low); stall_req_{if,id,ex,mem},
//   exc_req, eret_req, cp0_epc, id_next_isdelayslot in;
//   stall[5:0], flush, new_pc_valid, new_pc, id_isdelayslot,
//   stall_cycles out.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_req_if,
  input  logic        stall_req_id,
  input  logic        stall_req_ex,
  input  logic        stall_req_mem,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] cp0_epc,
  input  logic        id_next_isdelayslot,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        new_pc_valid,
  output logic [31:0] new_pc,
  output logic        id_isdelayslot,
  output logic [31:0] stall_cycles
);

  state_t      state;
  logic [31:0] target;
  logic        redirect;
  logic        bus_busy;

  // Deepest stalled stage wins.
  function automatic logic [5:0] stall_enc(
    input logic s_if,
    input logic s_id,
    input logic s_ex,
    input logic s_mem
  );
    if (s_mem)     return STALL_MEM;
    else if (s_ex) return STALL_EX;
    else if (s_id) return STALL_ID;
    else if (s_if) return STALL_IF;
    else           return STALL_NONE;
  endfunction

  assign redirect = exc_req | eret_req;
  assign bus_busy = stall_req_if | stall_req_mem;

  // Outputs are forced low while reset is held so the
  // pipeline sees a quiet controller regardless of inputs.
  always_comb begin
    stall        = STALL_NONE;
    flush        = 1'b0;
    new_pc_valid = 1'b0;
    new_pc       = 32'h0;
    if (resetn) begin
      case (state)
        RUN: begin
          if (redirect)
            stall = STALL_ALL;
          else
            stall = stall_enc(stall_req_if, stall_req_id,
                              stall_req_ex, stall_req_mem);
        end
        WAIT_BUS: stall = STALL_ALL;
        FLUSH: begin
          flush        = 1'b1;
          new_pc_valid = 1'b1;
          new_pc       = target;
        end
        default: stall = STALL_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= RUN;
      target <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            target <= exc_req ? EXC_VECTOR : cp0_epc;
            state  <= bus_busy ? WAIT_BUS : FLUSH;
          end
        end
        WAIT_BUS: begin
          if (!bus_busy)
            state <= FLUSH;
        end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      id_isdelayslot <= 1'b0;
    else if (flush)
      id_isdelayslot <= 1'b0;
    else if (!stall[2])
      id_isdelayslot <= id_next_isdelayslot;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_cycles <= 32'h0;
    else if (stall[1] && stall_cycles != 32'hFFFFFFFF)
      stall_cycles <= stall_cycles + 32'h1;
  end

endmodule
